// File: rtl/rtc_bus_driver_pkg.sv
// Purpose : shared FSM encoding, operation codes and bus-control decode for the RTC bus driver.
// Latency : none (constants, types and a pure function).
// Backpressure: none; the package holds no flow-controlled state.
// Contents: T_FASE_DEF, OP_ESC/OP_LEC, state constants, ctl_t and ctl_de_estado().
package rtc_pkg;

  localparam int T_FASE_DEF = 10;

  localparam logic OP_ESC = 1'b0;
  localparam logic OP_LEC = 1'b1;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] DIR_SETUP = 3'd1;
  localparam logic [2:0] DIR_PULSO = 3'd2;
  localparam logic [2:0] DIR_HOLD  = 3'd3;
  localparam logic [2:0] DAT_SETUP = 3'd4;
  localparam logic [2:0] DAT_PULSO = 3'd5;
  localparam logic [2:0] DAT_HOLD  = 3'd6;
  localparam logic [2:0] FIN       = 3'd7;

  typedef struct packed {
    logic cs_n;
    logic rd_n;
    logic wr_n;
    logic ad_sel;
    logic ad_oe;
  } ctl_t;

  // Bus control levels for a given state; IDLE and FIN share the inactive set.
  function automatic ctl_t ctl_de_estado(input logic [2:0] estado, input logic op);
    ctl_t c;
    logic esc;
    esc      = (op == OP_ESC);
    c.cs_n   = 1'b1;
    c.rd_n   = 1'b1;
    c.wr_n   = 1'b1;
    c.ad_sel = 1'b1;
    c.ad_oe  = 1'b0;
    case (estado)
      DIR_SETUP: begin c.cs_n = 1'b0; c.ad_sel = 1'b0; c.ad_oe = 1'b1; end
      // The address is always strobed with WR, even for a read.
      DIR_PULSO: begin c.cs_n = 1'b0; c.ad_sel = 1'b0; c.ad_oe = 1'b1; c.wr_n = 1'b0; end
      DIR_HOLD:  begin c.ad_sel = 1'b0; c.ad_oe = 1'b1; end
      DAT_SETUP: begin c.cs_n = 1'b0; c.ad_oe = esc; end
      DAT_PULSO: begin
        c.cs_n  = 1'b0;
        c.ad_oe = esc;
        if (esc) c.wr_n = 1'b0;
        else     c.rd_n = 1'b0;
      end
      DAT_HOLD:  c.ad_oe = esc;
      default:   ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/rtc_bus_driver_if.sv
// Purpose : request side and RTC multiplexed-bus side of the RTC bus driver.
// Latency : none (wiring only).
// Backpressure: none; requests are levels and ocupado tells the requester to wait.
// Ports: master = the driver (takes inicio_*, dir, dato, ad_in; drives bus, dato_leido, listo, ocupado);
//        slave  = the requester/RTC side, directions reversed.
interface rtc_bus_driver_if;
  logic       inicio_esc;
  logic       inicio_lec;
  logic [7:0] dir;
  logic [7:0] dato;
  logic [7:0] ad_in;
  logic [7:0] ad_out;
  logic       ad_oe;
  logic       ad_sel;
  logic       cs_n;
  logic       rd_n;
  logic       wr_n;
  logic [7:0] dato_leido;
  logic       listo;
  logic       ocupado;

  modport master (
    input  inicio_esc, inicio_lec, dir, dato, ad_in,
    output ad_out, ad_oe, ad_sel, cs_n, rd_n, wr_n, dato_leido, listo, ocupado
  );

  modport slave (
    output inicio_esc, inicio_lec, dir, dato, ad_in,
    input  ad_out, ad_oe, ad_sel, cs_n, rd_n, wr_n, dato_leido, listo, ocupado
  );
endinterface

// File: rtl/rtc_bus_driver_contador_fase.sv
// Purpose : 8-bit phase timer with synchronous clear and terminal-count flag.
// Latency : tc is combinational from the count; count advances every clk.
// Backpressure: none; the owner clears it on every state change.
// Ports: clk, reset (sync, active-high), clr (sync clear), tc (count == ULTIMO).
module contador_fase #(
  parameter logic [7:0] ULTIMO = 8'd9
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tc
);

  logic [7:0] cuenta;

  always_ff @(posedge clk) begin
    if (reset || clr) cuenta <= '0;
    else              cuenta <= cuenta + 8'd1;
  end

  assign tc = (cuenta == ULTIMO);

endmodule

// File: rtl/rtc_bus_driver.sv
// Purpose : drives one address+data access on a multiplexed-bus RTC (address always strobed with WR).
// Latency : request sampled at edge k -> listo high in the cycle after edge k+1+6*T_FASE.
// Backpressure: requests are ignored (not queued) from acceptance until ocupado has dropped again.
// Ports: clk, reset (sync, active-high), bus (rtc_bus_driver_if.master).
module rtc_bus_driver
  import rtc_pkg::*;
#(
  parameter int T_FASE = T_FASE_DEF
) (
  input  logic              clk,
  input  logic              reset,
  rtc_bus_driver_if.master  bus
);

  logic [2:0] estado, estado_sig;
  logic       op;
  logic [7:0] dir_q, dato_q;
  logic       tc, clr_fase, captura;
  ctl_t       ctl;

  // ocupado is registered one cycle behind the state, so it also gates IDLE:
  // this keeps the request from being taken in the cycle ocupado still shows FIN.
  always_comb begin
    estado_sig = estado;
    case (estado)
      IDLE:      if (!bus.ocupado && (bus.inicio_lec || bus.inicio_esc)) estado_sig = DIR_SETUP;
      DIR_SETUP: if (tc) estado_sig = DIR_PULSO;
      DIR_PULSO: if (tc) estado_sig = DIR_HOLD;
      DIR_HOLD:  if (tc) estado_sig = DAT_SETUP;
      DAT_SETUP: if (tc) estado_sig = DAT_PULSO;
      DAT_PULSO: if (tc) estado_sig = DAT_HOLD;
      DAT_HOLD:  if (tc) estado_sig = FIN;
      default:   estado_sig = IDLE;
    endcase
  end

  assign clr_fase = (estado_sig != estado) || (estado == IDLE);

  contador_fase #(.ULTIMO(8'(T_FASE - 1))) u_fase (
    .clk   (clk),
    .reset (reset),
    .clr   (clr_fase),
    .tc    (tc)
  );

  always_comb ctl = ctl_de_estado(estado, op);

  // Every output is registered from the current state, so the bus view trails
  // the state register by one cycle; phase lengths are unaffected.
  always_ff @(posedge clk) begin
    if (reset) begin
      estado         <= IDLE;
      op             <= OP_ESC;
      dir_q          <= '0;
      dato_q         <= '0;
      captura        <= 1'b0;
      bus.cs_n       <= 1'b1;
      bus.rd_n       <= 1'b1;
      bus.wr_n       <= 1'b1;
      bus.ad_sel     <= 1'b1;
      bus.ad_oe      <= 1'b0;
      bus.ad_out     <= '0;
      bus.dato_leido <= '0;
      bus.listo      <= 1'b0;
      bus.ocupado    <= 1'b0;
    end else begin
      estado <= estado_sig;
      if (estado == IDLE && estado_sig == DIR_SETUP) begin
        // Read wins when both requests are present.
        op     <= bus.inicio_lec ? OP_LEC : OP_ESC;
        dir_q  <= bus.dir;
        dato_q <= bus.dato;
      end
      bus.cs_n   <= ctl.cs_n;
      bus.rd_n   <= ctl.rd_n;
      bus.wr_n   <= ctl.wr_n;
      bus.ad_sel <= ctl.ad_sel;
      bus.ad_oe  <= ctl.ad_oe;
      case (estado)
        DIR_SETUP, DIR_PULSO, DIR_HOLD: bus.ad_out <= dir_q;
        DAT_SETUP, DAT_PULSO, DAT_HOLD: if (op == OP_ESC) bus.ad_out <= dato_q;
        default: ;
      endcase
      bus.listo   <= (estado == FIN);
      bus.ocupado <= (estado != IDLE);
      // captura marks the edge that ends the last rd_n-low cycle on the pins.
      captura <= (estado == DAT_PULSO) && tc && (op == OP_LEC);
      if (captura) bus.dato_leido <= bus.ad_in;
    end
  end

endmodule

// File: tb/tb_rtc_bus_driver.sv
module tb_rtc_bus_driver;

  localparam int TF0 = 10;
  localparam int TF1 = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       esc [2];
  logic       lec [2];
  logic [7:0] dir_v [2];
  logic [7:0] dato_v [2];
  logic [7:0] adin [2];

  rtc_bus_driver_if bus0();
  rtc_bus_driver_if bus1();

  assign bus0.inicio_esc = esc[0];
  assign bus0.inicio_lec = lec[0];
  assign bus0.dir        = dir_v[0];
  assign bus0.dato       = dato_v[0];
  assign bus0.ad_in      = adin[0];
  assign bus1.inicio_esc = esc[1];
  assign bus1.inicio_lec = lec[1];
  assign bus1.dir        = dir_v[1];
  assign bus1.dato       = dato_v[1];
  assign bus1.ad_in      = adin[1];

  rtc_bus_driver #(.T_FASE(TF0)) dut0 (.clk(clk), .reset(rst), .bus(bus0));
  rtc_bus_driver #(.T_FASE(TF1)) dut1 (.clk(clk), .reset(rst), .bus(bus1));

  // {cs_n, rd_n, wr_n, ad_sel, ad_oe, listo, ocupado, ad_out, dato_leido}
  logic [22:0] obs [2];
  logic [22:0] expv [2];
  assign obs[0] = {bus0.cs_n, bus0.rd_n, bus0.wr_n, bus0.ad_sel, bus0.ad_oe,
                   bus0.listo, bus0.ocupado, bus0.ad_out, bus0.dato_leido};
  assign obs[1] = {bus1.cs_n, bus1.rd_n, bus1.wr_n, bus1.ad_sel, bus1.ad_oe,
                   bus1.listo, bus1.ocupado, bus1.ad_out, bus1.dato_leido};

  typedef struct { int inst; int fin; } ent_t;
  ent_t sbq[$];

  int         checks = 0;
  int         errors = 0;
  int         ed = 0;
  bit         rnd_ad;
  bit         rst_ult;
  bit         armed [2];
  bit         act [2];
  bit         m_lec [2];
  int         k [2];
  int         libre [2];
  logic [7:0] m_dir [2];
  logic [7:0] m_dato [2];
  logic [7:0] m_leido [2];
  logic [7:0] m_adout [2];
  bit         tiene_prev [2];
  logic       prev_oe [2];
  logic       prev_cs [2];

  function automatic int tfase(input int i);
    return (i == 0) ? TF0 : TF1;
  endfunction

  // Reference: a transfer accepted at edge k shows phase p=(off-1)/T for
  // off=1..6T after edge k+off, FIN at off=6T+1; the driver is busy until
  // edge k+6T+3, when its ocupado flag has dropped again.
  task automatic modelo(input int i);
    int t, off, ph;
    bit pulso, datos;
    t  = tfase(i);
    ph = 7;
    if (rst) begin
      armed[i]   = 1'b1;
      act[i]     = 1'b0;
      libre[i]   = ed + 1;
      m_leido[i] = 8'h00;
      m_adout[i] = 8'h00;
      for (int j = sbq.size() - 1; j >= 0; j--)
        if (sbq[j].inst == i) sbq.delete(j);
    end else begin
      if (act[i]) begin
        off = ed - k[i];
        if (off > 6 * t + 1) act[i] = 1'b0;
        else begin
          ph = (off <= 6 * t) ? (off - 1) / t : 6;
          if (m_lec[i] && off == 5 * t + 1) m_leido[i] = adin[i];
          if (ph < 3) m_adout[i] = m_dir[i];
          else if (ph < 6 && !m_lec[i]) m_adout[i] = m_dato[i];
        end
      end
      if (armed[i] && (esc[i] || lec[i]) && ed >= libre[i]) begin
        ent_t e;
        act[i]    = 1'b1;
        k[i]      = ed;
        m_lec[i]  = lec[i];
        m_dir[i]  = dir_v[i];
        m_dato[i] = dato_v[i];
        libre[i]  = ed + 6 * t + 3;
        e.inst    = i;
        e.fin     = ed + 6 * t + 1;
        sbq.push_back(e);
      end
    end
    pulso = (ph == 1) || (ph == 4);
    datos = (ph >= 3) && (ph < 6);
    expv[i] = {!((ph < 6) && (ph % 3 != 2)),
               !(ph == 4 && m_lec[i]),
               !(pulso && (ph == 1 || !m_lec[i])),
               !(ph < 3),
               (ph < 3) || (datos && !m_lec[i]),
               ph == 6,
               ph <= 6,
               m_adout[i], m_leido[i]};
  endtask

  initial begin
    forever begin
      @(posedge clk);
      ed++;
      for (int i = 0; i < 2; i++) modelo(i);
      rst_ult = rst;
    end
  end

  // Monitor: per-cycle bus compare, strobe rules, listo scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (armed[i]) begin
          checks++;
          if (obs[i] !== expv[i]) begin
            errors++;
            $display("FAIL bus inst=%0d edge=%0d got=%h want=%h", i, ed, obs[i], expv[i]);
          end
          checks++;
          if (!(obs[i][21] | obs[i][20])) begin
            errors++;
            $display("FAIL rd_wr_both_low inst=%0d edge=%0d rd_n=%b wr_n=%b", i, ed, obs[i][21], obs[i][20]);
          end
          if (tiene_prev[i] && !rst_ult) begin
            checks++;
            if (obs[i][18] !== prev_oe[i] && prev_cs[i] !== 1'b1) begin
              errors++;
              $display("FAIL oe_toggle_cs inst=%0d edge=%0d oe=%b prev_cs_n=%b want prev_cs_n=1", i, ed, obs[i][18], prev_cs[i]);
            end
          end
          prev_oe[i]    = obs[i][18];
          prev_cs[i]    = obs[i][22];
          tiene_prev[i] = 1'b1;
          if (obs[i][17] === 1'b1) begin
            int j;
            j = -1;
            for (int q = 0; q < sbq.size(); q++)
              if (j < 0 && sbq[q].inst == i) j = q;
            checks++;
            if (j < 0) begin
              errors++;
              $display("FAIL listo_unexpected inst=%0d edge=%0d got listo=1 want no pending transfer", i, ed);
            end else begin
              if (sbq[j].fin != ed) begin
                errors++;
                $display("FAIL listo_edge inst=%0d got=%0d want=%0d", i, ed, sbq[j].fin);
              end
              sbq.delete(j);
            end
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_ad) begin
      adin[0] = 8'($urandom);
      adin[1] = 8'($urandom);
    end
  endtask

  task automatic esperar(input int n);
    repeat (n) tick();
  endtask

  task automatic pedir(input int i, input bit e, input bit l, input logic [7:0] d,
                       input logic [7:0] x, input int len);
    esc[i]    = e;
    lec[i]    = l;
    dir_v[i]  = d;
    dato_v[i] = x;
    esperar(len);
    esc[i] = 1'b0;
    lec[i] = 1'b0;
  endtask

  task automatic pedir_azar(input int i);
    int s;
    s = int'($urandom_range(2, 0));
    pedir(i, s != 1, s != 0, 8'($urandom), 8'($urandom), int'($urandom_range(3, 1)));
  endtask

  initial begin
    rst    = 1'b1;
    rnd_ad = 1'b1;
    for (int i = 0; i < 2; i++) begin
      esc[i] = 1'b0; lec[i] = 1'b0; dir_v[i] = 8'h00; dato_v[i] = 8'h00; adin[i] = 8'h00;
    end
    esperar(3);
    rst = 1'b0;
    esperar(2);

    // Write 21/45 on the T=10 driver.
    pedir(0, 1'b1, 1'b0, 8'h21, 8'h45, 1);
    esperar(70);
    // Read 22 with the RTC returning 37.
    rnd_ad  = 1'b0;
    adin[0] = 8'h37;
    pedir(0, 1'b0, 1'b1, 8'h22, 8'h99, 1);
    esperar(70);
    rnd_ad = 1'b1;
    // Both requests together: must be a read.
    pedir(0, 1'b1, 1'b1, 8'h30, 8'hc3, 1);
    esperar(70);
    // Second request pulsed during DAT_PULSO of the first.
    pedir(0, 1'b1, 1'b0, 8'h11, 8'h77, 1);
    esperar(4 * TF0 + 3);
    pedir(0, 1'b0, 1'b1, 8'h12, 8'h00, 1);
    esperar(70);
    // Reset while the address strobe is active.
    pedir(0, 1'b1, 1'b0, 8'h5a, 8'ha5, 1);
    esperar(TF0 + 3);
    rst = 1'b1;
    esperar(1);
    rst = 1'b0;
    esperar(70);
    // Randomized traffic, including requests that land while busy.
    repeat (12) begin
      pedir_azar(0);
      esperar(int'($urandom_range(75, 0)));
    end
    esperar(70);

    // T=1 driver: directed write and read, an abort, then random traffic.
    pedir(1, 1'b1, 1'b0, 8'h21, 8'h45, 1);
    esperar(10);
    pedir(1, 1'b0, 1'b1, 8'h22, 8'h00, 1);
    esperar(10);
    pedir(1, 1'b1, 1'b0, 8'h40, 8'h41, 1);
    esperar(1);
    rst = 1'b1;
    esperar(1);
    rst = 1'b0;
    esperar(10);
    repeat (30) begin
      pedir_azar(1);
      esperar(int'($urandom_range(12, 0)));
    end
    esperar(20);

    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL pending_listo got=%0d outstanding want=0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
